// File: rtl/pair_stream_tx_if.sv
// Handshake plus two-lane stream bundle for pair_stream_tx.
// master = upstream word source / lane observer, slave = the transmitter.
interface pair_stream_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             a_o;
    logic             b_o;
    logic             frame_o;
    logic             done_o;

    modport master (
        output data_i, valid_i,
        input  ready_o, a_o, b_o, frame_o, done_o
    );

    modport slave (
        input  data_i, valid_i,
        output ready_o, a_o, b_o, frame_o, done_o
    );
endinterface

// File: rtl/pair_stream_tx.sv
// Two-lane serial transmitter: WIDTH-bit word out two bits per clock, LSB pair first.
// Optional trailing parity beat when PAIR_TX_PARITY_EN is defined.
module pair_stream_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    pair_stream_tx_if.slave  bus
);
    localparam int BEATS = WIDTH / 2;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(BEATS - 1);

`ifdef PAIR_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

    function automatic logic lane_par(input logic [WIDTH-1:0] w, input int off);
        logic p;
        p = 1'b0;
        for (int i = 0; i < BEATS; i++) p ^= w[2*i+off];
        return p;
    endfunction

    logic par_a_q, par_a_d;
    logic par_b_q, par_b_d;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             frame_q, frame_d;
    logic             done_q, done_d;

    assign bus.ready_o = (state_q == IDLE) && !rst;
    assign bus.a_o     = a_q;
    assign bus.b_o     = b_q;
    assign bus.frame_o = frame_q;
    assign bus.done_o  = done_q;

    // Lane flops hold the beat for the *next* cycle, so each branch computes
    // what the following cycle must show.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        a_d     = 1'b0;
        b_d     = 1'b0;
        frame_d = 1'b0;
        done_d  = 1'b0;
`ifdef PAIR_TX_PARITY_EN
        par_a_d = par_a_q;
        par_b_d = par_b_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    sreg_d  = bus.data_i;
                    cnt_d   = CNT_LOAD;
                    a_d     = bus.data_i[0];
                    b_d     = bus.data_i[1];
                    frame_d = 1'b1;
                    state_d = SHIFT;
`ifdef PAIR_TX_PARITY_EN
                    par_a_d = lane_par(bus.data_i, 0);
                    par_b_d = lane_par(bus.data_i, 1);
`endif
                end
            end
            SHIFT: begin
                sreg_d = sreg_q >> 2;
                if (cnt_q == '0) begin
`ifdef PAIR_TX_PARITY_EN
                    state_d = PAR;
                    a_d     = par_a_q;
                    b_d     = par_b_q;
                    frame_d = 1'b1;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                    a_d     = sreg_d[0];
                    b_d     = sreg_d[1];
                    frame_d = 1'b1;
                end
            end
`ifdef PAIR_TX_PARITY_EN
            PAR: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef PAIR_TX_PARITY_EN
            par_a_q <= 1'b0;
            par_b_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            frame_q <= frame_d;
            done_q  <= done_d;
`ifdef PAIR_TX_PARITY_EN
            par_a_q <= par_a_d;
            par_b_q <= par_b_d;
`endif
        end
    end
endmodule

// File: tb/tb_pair_stream_tx.sv
// Directed bench for pair_stream_tx (WIDTH=8 and WIDTH=2 instances).
// Outputs are sampled on the falling edge; inputs change there too.
module tb_pair_stream_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pair_stream_tx_if #(.WIDTH(8)) bus8 ();
    pair_stream_tx_if #(.WIDTH(2)) bus2 ();

    pair_stream_tx #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    pair_stream_tx #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Observed output word is {frame, a, b, done}.
    task automatic test_reset();
        logic [3:0] obs;
        rst = 1'b1; bus8.valid_i = 1'b1; bus8.data_i = 8'hB4;
        bus2.valid_i = 1'b1; bus2.data_i = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
            checks++;
            if (obs !== 4'b0000 || bus8.ready_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_outs cyc%0d: got fabd=%b ready=%b want 0000 ready=0", c, obs, bus8.ready_o);
            end
        end
        bus8.valid_i = 1'b0; bus2.valid_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
        checks++;
        if (obs !== 4'b0000 || bus8.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got fabd=%b ready=%b want 0000 ready=1", obs, bus8.ready_o);
        end
    endtask

    task automatic test_single();
        logic [7:0] w;
        logic [3:0] obs, exp;
        w = 8'hB4;
        bus8.data_i = w; bus8.valid_i = 1'b1;
        @(negedge clk);
        bus8.valid_i = 1'b0; bus8.data_i = 8'h00;
        for (int k = 0; k < 4; k++) begin
            obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
            exp = {1'b1, w[2*k], w[2*k+1], 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single_beat%0d: got fabd=%b want %b", k, obs, exp);
            end
            @(negedge clk);
        end
`ifdef PAIR_TX_PARITY_EN
        obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
        checks++;
        if (obs !== 4'b1000) begin
            errors++;
            $display("FAIL single_parity: got fabd=%b want 1000", obs);
        end
        @(negedge clk);
`endif
        obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
        checks++;
        if (obs !== 4'b0001 || bus8.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL single_done: got fabd=%b ready=%b want 0001 ready=1", obs, bus8.ready_o);
        end
        @(negedge clk);
        obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL single_after: got fabd=%b want 0000", obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs;
        bus8.data_i = 8'hFF; bus8.valid_i = 1'b1;
        @(negedge clk);
        bus8.data_i = 8'h00;
        for (int k = 0; k < 4; k++) begin
            obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
            checks++;
            if (obs !== 4'b1110 || bus8.ready_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ff_beat%0d: got fabd=%b ready=%b want 1110 ready=0", k, obs, bus8.ready_o);
            end
            @(negedge clk);
        end
`ifdef PAIR_TX_PARITY_EN
        obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
        checks++;
        if (obs !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_ff_parity: got fabd=%b want 1000", obs);
        end
        @(negedge clk);
`endif
        obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
        checks++;
        if (obs !== 4'b0001 || bus8.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: got fabd=%b ready=%b want 0001 ready=1", obs, bus8.ready_o);
        end
        @(negedge clk);
        bus8.valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
            checks++;
            if (obs !== 4'b1000) begin
                errors++;
                $display("FAIL b2b_00_beat%0d: got fabd=%b want 1000", k, obs);
            end
            @(negedge clk);
        end
`ifdef PAIR_TX_PARITY_EN
        obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
        checks++;
        if (obs !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_00_parity: got fabd=%b want 1000", obs);
        end
        @(negedge clk);
`endif
        obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_done2: got fabd=%b want 0001", obs);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        logic [3:0] obs, exp;
        bus8.data_i = 8'hB4; bus8.valid_i = 1'b1;
        @(negedge clk);
        bus8.valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
        checks++;
        if (obs !== 4'b1110) begin
            errors++;
            $display("FAIL midrst_beat2: got fabd=%b want 1110", obs);
        end
        rst = 1'b1;
        @(negedge clk);
        obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
        checks++;
        if (obs !== 4'b0000 || bus8.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: got fabd=%b ready=%b want 0000 ready=0", obs, bus8.ready_o);
        end
        rst = 1'b0;
        @(negedge clk);
        obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
        checks++;
        if (obs !== 4'b0000 || bus8.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midrst_noresume: got fabd=%b ready=%b want 0000 ready=1", obs, bus8.ready_o);
        end
        w = 8'h01;
        bus8.data_i = w; bus8.valid_i = 1'b1;
        @(negedge clk);
        bus8.valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
            exp = (k == 0) ? 4'b1100 : 4'b1000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midrst_01_beat%0d: got fabd=%b want %b", k, obs, exp);
            end
            @(negedge clk);
        end
`ifdef PAIR_TX_PARITY_EN
        obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL parity_01: got fabd=%b want 1100", obs);
        end
        @(negedge clk);
`endif
        obs = {bus8.frame_o, bus8.a_o, bus8.b_o, bus8.done_o};
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_01_done: got fabd=%b want 0001", obs);
        end
        @(negedge clk);
    endtask

    task automatic test_width2();
        logic [3:0] obs;
        bus2.data_i = 2'b10; bus2.valid_i = 1'b1;
        @(negedge clk);
        bus2.valid_i = 1'b0; bus2.data_i = 2'b00;
        obs = {bus2.frame_o, bus2.a_o, bus2.b_o, bus2.done_o};
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("FAIL w2_beat: got fabd=%b want 1010", obs);
        end
        @(negedge clk);
`ifdef PAIR_TX_PARITY_EN
        obs = {bus2.frame_o, bus2.a_o, bus2.b_o, bus2.done_o};
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("FAIL w2_parity: got fabd=%b want 1010", obs);
        end
        @(negedge clk);
`endif
        obs = {bus2.frame_o, bus2.a_o, bus2.b_o, bus2.done_o};
        checks++;
        if (obs !== 4'b0001 || bus2.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL w2_done: got fabd=%b ready=%b want 0001 ready=1", obs, bus2.ready_o);
        end
        @(negedge clk);
        obs = {bus2.frame_o, bus2.a_o, bus2.b_o, bus2.done_o};
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL w2_after: got fabd=%b want 0000", obs);
        end
    endtask

    initial begin
        bus8.data_i = '0; bus8.valid_i = 1'b0;
        bus2.data_i = '0; bus2.valid_i = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid_frame();
        test_width2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
